// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier: signed 16x16 -> 32, one Booth digit per clock, one shared 32-bit adder.
// Optional early termination when the remaining multiplier digits are all zero: define BOOTH_MUL_EARLY_TERM_EN.
module booth_mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [16:0] mplr;
    logic [2:0]  step;
  } dp_t;

  state_e      state, state_nxt;
  dp_t         dp, dp_nxt;
  logic [31:0] product_nxt;
  logic [31:0] pp, sum;
  logic [16:0] mplr_sh;
  logic        last_digit;

  // Booth digit recode of the current triplet
  always_comb begin
    pp = '0;
    case (dp.mplr[2:0])
      3'b001, 3'b010: pp = dp.mcand;
      3'b011:         pp = dp.mcand << 1;
      3'b100:         pp = ~(dp.mcand << 1) + 32'd1;
      3'b101, 3'b110: pp = ~dp.mcand + 32'd1;
      default:        pp = '0;
    endcase
  end

  assign sum     = dp.acc + pp;
  assign mplr_sh = {{2{dp.mplr[16]}}, dp.mplr[16:2]};

`ifdef BOOTH_MUL_EARLY_TERM_EN
  // All-zero / all-one remainder means every later digit recodes to 0
  assign last_digit = (dp.step == 3'd7) || (mplr_sh == '0) || (mplr_sh == '1);
`else
  assign last_digit = (dp.step == 3'd7);
`endif

  always_comb begin
    state_nxt   = state;
    dp_nxt      = dp;
    product_nxt = product;
    case (state)
      IDLE: begin
        if (in_valid) begin
          dp_nxt.acc   = '0;
          dp_nxt.mcand = {{16{a[15]}}, a};
          dp_nxt.mplr  = {b, 1'b0};
          dp_nxt.step  = '0;
          state_nxt    = RUN;
        end
      end
      RUN: begin
        dp_nxt.acc   = sum;
        dp_nxt.mcand = dp.mcand << 2;
        dp_nxt.mplr  = mplr_sh;
        dp_nxt.step  = dp.step + 3'd1;
        if (last_digit) begin
          product_nxt = sum;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      dp      <= '0;
      product <= '0;
    end else begin
      state   <= state_nxt;
      dp      <= dp_nxt;
      product <= product_nxt;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
